// File: rtl/pc_stack_if.sv
// pc_stack_if
// Command/status bundle between the control unit and the PC/return-stack.
// Parameters:
//   W - address width in bits, D - return-stack depth in entries.
// Signals:
//   in      - target address for load/call, or load offset in the relative build
//   inc     - increment request
//   load    - jump request
//   call    - push out+1 and jump to in
//   ret     - pop the stack into out
//   stall   - freeze all state this cycle
//   err_clr - clear sticky error flags
//   out     - current PC
//   depth   - number of valid stack entries
//   full    - depth == D
//   empty   - depth == 0
//   err_ovf - sticky: call attempted while full
//   err_unf - sticky: ret attempted while empty
// Modports: master = control unit side, slave = pc_stack side.
interface pc_stack_if #(
    parameter int W = 16,
    parameter int D = 8
);
    localparam int DW = $clog2(D + 1);

    logic [W-1:0]  in;
    logic          inc;
    logic          load;
    logic          call;
    logic          ret;
    logic          stall;
    logic          err_clr;
    logic [W-1:0]  out;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          err_ovf;
    logic          err_unf;

    modport master (
        output in, inc, load, call, ret, stall, err_clr,
        input  out, depth, full, empty, err_ovf, err_unf
    );

    modport slave (
        input  in, inc, load, call, ret, stall, err_clr,
        output out, depth, full, empty, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_stack.sv
// pc_stack
// Program counter with a hardware call/return stack for the CPU fetch path.
// Each rising clock edge the PC holds, increments, loads, calls (pushes
// out+1 and jumps) or returns (pops). Priority: stall > ret > call > load > inc.
// Sticky overflow/underflow flags record rejected calls and returns.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset_n - asynchronous active-low reset
//   bus     - pc_stack_if slave modport (commands in, PC/stack status out)
// Configuration macro:
//   PC_STACK_REL_EN - when defined, load adds in (two's-complement offset)
//                     to the PC; call stays absolute. Default: absolute load.
module pc_stack #(
    parameter int W = 16,
    parameter int D = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_stack_if.slave bus
);
    localparam int DW = $clog2(D + 1);
    // Stack index width; depth itself needs one extra code for "full".
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  r_pc;
    logic [DW-1:0] r_depth;
    logic          r_errOvf;
    logic          r_errUnf;
    logic [W-1:0]  r_stack [D];

    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_pushIdx;
    logic [AW-1:0] w_popIdx;
    logic [W-1:0]  w_pcPlusOne;
    logic [W-1:0]  w_loadTarget;
    logic          w_retOk;
    logic          w_retBad;
    logic          w_callOk;
    logic          w_callBad;
    logic          w_loadReq;
    logic          w_incReq;

    assign w_full      = (r_depth == DW'(D));
    assign w_empty     = (r_depth == '0);
    assign w_pushIdx   = AW'(r_depth);
    assign w_popIdx    = AW'(r_depth - DW'(1));
    assign w_pcPlusOne = r_pc + W'(1);

`ifdef PC_STACK_REL_EN
    assign w_loadTarget = r_pc + bus.in;
`else
    assign w_loadTarget = bus.in;
`endif

    // Decode the single winning command; stall masks everything.
    assign w_retOk   = ~bus.stall & bus.ret & ~w_empty;
    assign w_retBad  = ~bus.stall & bus.ret & w_empty;
    assign w_callOk  = ~bus.stall & ~bus.ret & bus.call & ~w_full;
    assign w_callBad = ~bus.stall & ~bus.ret & bus.call & w_full;
    assign w_loadReq = ~bus.stall & ~bus.ret & ~bus.call & bus.load;
    assign w_incReq  = ~bus.stall & ~bus.ret & ~bus.call & ~bus.load & bus.inc;

    // PC, depth and sticky error flags. Rejected calls/returns leave PC and
    // depth alone and only raise their flag; a flag being set in the same
    // cycle as err_clr stays set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= '0;
            r_depth  <= '0;
            r_errOvf <= 1'b0;
            r_errUnf <= 1'b0;
        end else if (!bus.stall) begin
            if (w_retOk) begin
                r_pc    <= r_stack[w_popIdx];
                r_depth <= r_depth - DW'(1);
            end else if (w_callOk) begin
                r_pc    <= bus.in;
                r_depth <= r_depth + DW'(1);
            end else if (w_loadReq) begin
                r_pc <= w_loadTarget;
            end else if (w_incReq) begin
                r_pc <= w_pcPlusOne;
            end
            r_errOvf <= w_callBad | (r_errOvf & ~bus.err_clr);
            r_errUnf <= w_retBad  | (r_errUnf & ~bus.err_clr);
        end
    end

    // Stack storage is not reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        if (w_callOk) begin
            r_stack[w_pushIdx] <= w_pcPlusOne;
        end
    end

    assign bus.out     = r_pc;
    assign bus.depth   = r_depth;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.err_ovf = r_errOvf;
    assign bus.err_unf = r_errUnf;
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware call/return stack, the successor to the 16-bit load/increment/reset counter. Holds the current instruction address and updates it once per clock by hold, increment, absolute load, call (push return address, jump) or return (pop). Sits in the CPU fetch path: `out` drives instruction memory and the control unit drives the command inputs. Adds stall, stack depth reporting and sticky overflow/underflow error flags.

## Interface
- `W`, 16, address width in bits (2..32).
- `D`, 8, return-stack depth in entries (1..64).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  W  target address for load/call, or offset for relative load when enabled.
- `inc`  in  1  increment request.
- `load`  in  1  jump request.
- `call`  in  1  push `out`+1 onto the stack, then jump to `in`.
- `ret`  in  1  pop the stack into `out`.
- `stall`  in  1  freeze all state for this cycle.
- `err_clr`  in  1  clear sticky error flags.
- `out`  out  W  current PC (registered).
- `depth`  out  $clog2(D+1)  number of valid stack entries.
- `full`  out  1  `depth == D`.
- `empty`  out  1  `depth == 0`.
- `err_ovf`  out  1  sticky: call attempted while full.
- `err_unf`  out  1  sticky: ret attempted while empty.

## Operation
- Reset (`reset_n` low): `out`=0, `depth`=0, `err_ovf`=`err_unf`=0, `empty`=1, `full`=0. Stack contents need not be cleared.
- Per-edge priority, highest first: stall > ret > call > load > inc > hold.
- stall: `out`, stack, depth, errors unchanged; `err_clr` also ignored.
- ret, not empty: `out` <= top entry; depth -= 1.
- ret, empty: `out` held; depth held; `err_unf` <= 1.
- call, not full: stack[depth] <= (`out`+1) mod 2^W; depth += 1; `out` <= `in`.
- call, full: rejected entirely; `out` held; stack unchanged; `err_ovf` <= 1.
- load: `out` <= `in` (or relative target, see Configuration).
- inc: `out` <= (`out`+1) mod 2^W; 2^W−1 wraps to 0.
- No request: `out` held.
- `err_clr` (not stalled): both error flags <= 0 unless the same cycle sets one, in which case set wins.
- Error flags do not affect normal operation; PC continues after an error.
- Stack is LIFO, indexed by `depth`; no wrap-around of stack pointer.

## Timing
- Single-cycle latency: command sampled at edge N, new `out`/`depth` visible after edge N.
- `full`, `empty` decoded combinationally from registered `depth`.
- Return address is `out`+1 of the calling cycle, not the target.
- Back-to-back call/ret in consecutive cycles supported at full rate.
- `reset_n` assertion takes effect immediately, independent of `clk`; deassertion is synchronised externally.
- Reset mid-sequence discards all stack contents and errors.

## Configuration
- Macro `PC_STACK_REL_EN`.
- Defined: `load` computes `out` <= (`out` + `in`) mod 2^W, `in` treated as two's-complement offset; call remains absolute.
- Undefined: `load` is absolute, `out` <= `in`.
- All other behaviour identical in both builds.

## Test plan
- Reset then 3 cycles `inc`=1 (W=16) -> `out`=0,1,2,3; set `out`=0xFFFF via load, `inc` -> `out`=0x0000.
- At `out`=0x0010, `call` `in`=0x0100 -> `out`=0x0100, `depth`=1; `ret` -> `out`=0x0011, `depth`=0, `empty`=1.
- D=4: five calls from 0x0000 each to `in`=0x0020 -> after 4th `full`=1; 5th leaves `out`=0x0020, `depth`=4, `err_ovf`=1; `err_clr` -> 0.
- `ret` with empty stack at `out`=0x0042 -> `out`=0x0042, `err_unf`=1; `ret`,`call`,`load`,`inc` all high with `depth`=1 -> ret wins.
- `stall`=1 with `call`=1 -> `out`, `depth` unchanged; `reset_n` pulse low between edges with `depth`=3 -> `out`=0, `depth`=0 immediately.
- `PC_STACK_REL_EN` defined: `out`=0x0100, `load` `in`=0xFFF0 -> `out`=0x00F0; undefined -> `out`=0xFFF0.
